// File: rtl/operand_fetch.sv
// operand_fetch
// -----------------------------------------------------------------------------
// Operand-fetch and hazard-interlock stage on the read side of the register
// file. Decoded instructions arrive over a valid/ready handshake, the source
// indices are driven straight to the register file read ports, and a
// per-register busy scoreboard tracks destinations whose writeback has not
// yet been seen. RAW and WAW hazards stall the input; accepted instructions
// land in a one-entry output register presented to execute over a second
// valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer holds its payload
// stable while valid=1 and ready=0. in_ready never depends on in_valid.
//
// Optional feature: define OPFETCH_BYPASS_EN to forward same-cycle
// writeback data (wb_data) into a source operand, clearing the RAW stall
// in the cycle the matching writeback is seen. Without it the operands
// always come from the register file and wb_data is unused.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          decoded instruction handshake
//   in_rs1, in_rs2, in_rd      source / destination register indices
//   in_rd_we                   instruction writes in_rd
//   rf_rs1, rf_rs2             register file read addresses (= in_rs1/in_rs2)
//   rf_rdata1, rf_rdata2       register file read data (same cycle)
//   wb_en, wb_rd, wb_data      writeback committed at this clock edge
//   flush                      synchronous flush of scoreboard and output
//   out_valid/out_ready        operand handshake to execute
//   out_op1, out_op2           registered operands
//   out_rd, out_rd_we          registered destination and write enable
//   stall_count                saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rd_we,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic            out_rd_we,
    output logic [15:0]     stall_count
);

    localparam int NREG = 1 << AW;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            byp1;
    logic            byp2;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] op1_sel;
    logic [XLEN-1:0] op2_sel;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

`ifdef OPFETCH_BYPASS_EN
    // Writeback to x0 is never forwarded; x0 reads as zero regardless.
    assign byp1 = wb_en && (wb_rd == in_rs1) && (in_rs1 != '0);
    assign byp2 = wb_en && (wb_rd == in_rs2) && (in_rs2 != '0);
`else
    logic unused_wb_data;
    assign byp1           = 1'b0;
    assign byp2           = 1'b0;
    assign unused_wb_data = ^wb_data;
`endif

    // The WAW term has no bypass: the older write must retire first so the
    // scoreboard bit always belongs to the youngest in-flight writer.
    assign hazard = (busy[in_rs1] && !byp1) ||
                    (busy[in_rs2] && !byp2) ||
                    (busy[in_rd]  && in_rd_we);

    assign in_ready = !hazard && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        op1_sel = rf_rdata1;
        if (in_rs1 == '0) begin
            op1_sel = '0;
        end else if (byp1) begin
            op1_sel = wb_data;
        end
    end

    always_comb begin
        op2_sel = rf_rdata2;
        if (in_rs2 == '0) begin
            op2_sel = '0;
        end else if (byp2) begin
            op2_sel = wb_data;
        end
    end

    // Clear first, then set, so a same-index set and clear leaves the bit set.
    // A clear of a non-busy bit is naturally a no-op.
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (accept && in_rd_we && (in_rd != '0)) begin
            busy_nxt[in_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
        if (flush) begin
            busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Output register FSM. accept is already 0 while flush is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (!accept && out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                out_op1   <= op1_sel;
                out_op2   <= op2_sel;
                out_rd    <= in_rd;
                out_rd_we <= in_rd_we;
            end
        end
    end

    assign out_valid = (state == FULL);

    // Counts only cycles lost to hazards, not to backpressure or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (in_valid && hazard && !flush && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
